// File: rtl/sys_defs.sv
// Shared rename-stage definitions: register counts and the TAG bundle
// passed between the free list, map table and ROB.
package sys_defs;

  localparam int PHYS_REGS  = 64;
  localparam int ARCH_REGS  = 32;
  localparam int PHYS_IDX_W = $clog2(PHYS_REGS);

  // Free-list geometry; DEPTH must stay a power of two so pointers wrap naturally.
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = FL_IDX_W + 1;

  typedef struct packed {
    logic [PHYS_IDX_W-1:0] phys_reg;
    logic                  valid;
    logic                  ready;
  } TAG;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags for the rename stage.
// Dispatch pops from head, retire pushes the old tag at tail, and a
// squash rewinds head to the retire pointer so every speculative
// allocation returns to the list in one cycle.
module free_list
  import sys_defs::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                dispatch_en,
  output TAG                  free_tag,
  input  logic                retire_en,
  input  TAG                  retire_tag,
  input  logic                squash,
  output logic                empty,
  output logic [FL_CNT_W-1:0] free_count
);

  logic [PHYS_IDX_W-1:0] r_buf [FL_DEPTH];
  logic [FL_IDX_W-1:0]   r_head;
  logic [FL_IDX_W-1:0]   r_tail;
  logic [FL_IDX_W-1:0]   r_retire_head;
  logic [FL_CNT_W-1:0]   r_count;

  logic                  w_pop;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_full;
  logic [FL_IDX_W-1:0]   w_tail_nxt;
  logic [FL_IDX_W-1:0]   w_retire_head_nxt;
  logic [FL_IDX_W-1:0]   w_span;
  logic [FL_CNT_W-1:0]   w_count_nxt;
  logic                  w_unused_ready;

  assign w_unused_ready = retire_tag.ready;

  // Output view of the head entry; zero latency so the map table samples it with dispatch_en.
  always_comb begin
    free_tag.phys_reg = r_buf[r_head];
    free_tag.valid    = (r_count != '0);
    free_tag.ready    = 1'b0;
    empty             = (r_count == '0);
    free_count        = r_count;
  end

  // Pop/push qualification and next-state pointer and count arithmetic.
  always_comb begin
    w_full            = (r_count == FL_CNT_W'(FL_DEPTH));
    w_pop             = dispatch_en & ~empty & ~squash;
    w_push_req        = retire_en & retire_tag.valid;
    w_push            = w_push_req & ~w_full;
    w_tail_nxt        = w_push ? r_tail + 1'b1 : r_tail;
    w_retire_head_nxt = w_push ? r_retire_head + 1'b1 : r_retire_head;
    w_span            = w_tail_nxt - w_retire_head_nxt;
    w_count_nxt       = r_count;
    if (squash) begin
      // Everything not yet retired comes back: free = DEPTH minus retired-but-unrecycled span.
      w_count_nxt = FL_CNT_W'(FL_DEPTH) - {1'b0, w_span};
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // State update; reset reloads the list with the tags not mapped architecturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_buf[i] <= PHYS_IDX_W'(ARCH_REGS + i);
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_retire_head <= '0;
      r_count       <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (w_push) begin
        r_buf[r_tail] <= retire_tag.phys_reg;
      end
      if (squash) begin
        r_head <= w_retire_head_nxt;
      end else if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_tail        <= w_tail_nxt;
      r_retire_head <= w_retire_head_nxt;
      r_count       <= w_count_nxt;
    end
  end

  // A retire into a full list means the ROB and free list disagree; the push is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_no_push_when_full: assert (!(w_push_req && w_full));
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed rename scenarios followed by random
// dispatch/retire/squash traffic, checked against a queue-level model.
module tb_free_list;
  import sys_defs::*;

  logic                clock;
  logic                reset;
  logic                dispatch_en;
  TAG                  free_tag;
  logic                retire_en;
  TAG                  retire_tag;
  logic                squash;
  logic                empty;
  logic [FL_CNT_W-1:0] free_count;

  int n_vec = 0;
  int n_err = 0;

  // Model: free tags in pop order, and allocations not yet retired (oldest first).
  int free_q[$];
  int inflight_q[$];

  free_list dut (
    .clock      (clock),
    .reset      (reset),
    .dispatch_en(dispatch_en),
    .free_tag   (free_tag),
    .retire_en  (retire_en),
    .retire_tag (retire_tag),
    .squash     (squash),
    .empty      (empty),
    .free_count (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    inflight_q.delete();
    for (int i = 0; i < FL_DEPTH; i++) free_q.push_back(ARCH_REGS + i);
  endtask

  task automatic check_outputs();
    chk("valid", 32'(free_tag.valid), 32'(free_q.size() != 0));
    chk("empty", 32'(empty), 32'(free_q.size() == 0));
    chk("free_count", 32'(free_count), 32'(free_q.size()));
    chk("ready", 32'(free_tag.ready), 32'd0);
    chk("count_bound", 32'(free_count <= FL_DEPTH), 32'd1);
    if (free_q.size() != 0) chk("free_tag", 32'(free_tag.phys_reg), 32'(free_q[0]));
  endtask

  task automatic model_update(input logic d, input logic ren, input logic rv,
                              input logic [PHYS_IDX_W-1:0] rt, input logic sq);
    int t;
    if (d && !sq && free_q.size() != 0) begin
      t = free_q.pop_front();
      inflight_q.push_back(t);
    end
    if (ren && rv) begin
      void'(inflight_q.pop_front());
      free_q.push_back(int'(rt));
    end
    if (sq) begin
      free_q = {inflight_q, free_q};
      inflight_q.delete();
    end
  endtask

  // One clock of stimulus: check state, drive, clock, advance model, settle on negedge.
  task automatic step(input logic d, input logic ren, input logic rv,
                      input logic [PHYS_IDX_W-1:0] rt, input logic sq);
    check_outputs();
    dispatch_en = d;
    retire_en   = ren;
    retire_tag  = '{phys_reg: rt, valid: rv, ready: 1'b0};
    squash      = sq;
    @(posedge clock);
    model_update(d, ren, rv, rt, sq);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    dispatch_en = 1'b1;
    retire_en   = 1'b1;
    retire_tag  = '{phys_reg: 6'd3, valid: 1'b1, ready: 1'b0};
    squash      = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset       = 1'b0;
    dispatch_en = 1'b0;
    retire_en   = 1'b0;
    model_reset();
  endtask

  initial begin
    logic d, ren, rv, sq;
    logic [PHYS_IDX_W-1:0] rt;

    do_reset();
    chk("rst_tag", 32'(free_tag.phys_reg), 32'(ARCH_REGS));
    chk("rst_valid", 32'(free_tag.valid), 32'd1);
    chk("rst_empty", 32'(empty), 32'd0);
    chk("rst_count", 32'(free_count), 32'(FL_DEPTH));

    // Drain the whole list in order.
    for (int i = 0; i < FL_DEPTH; i++) begin
      chk("drain_tag", 32'(free_tag.phys_reg), 32'(ARCH_REGS + i));
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(free_count), 32'd0);

    // Dispatch while empty is ignored.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("empty_valid", 32'(free_tag.valid), 32'd0);
    chk("empty_count", 32'(free_count), 32'd0);

    // Push into an empty list alongside dispatch: no bypass.
    step(1'b1, 1'b1, 1'b1, 6'd5, 1'b0);
    chk("nobypass_tag", 32'(free_tag.phys_reg), 32'd5);
    chk("nobypass_count", 32'(free_count), 32'd1);

    // Dispatch 3, retire 1, squash.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("d3_tag", 32'(free_tag.phys_reg), 32'(ARCH_REGS + i));
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 6'd7, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("squash_tag", 32'(free_tag.phys_reg), 32'd33);
    chk("squash_count", 32'(free_count), 32'(FL_DEPTH));
    for (int i = 0; i < FL_DEPTH - 1; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("tail_tag7", 32'(free_tag.phys_reg), 32'd7);

    // Squash with a same-cycle retire and dispatch.
    step(1'b1, 1'b1, 1'b1, 6'd9, 1'b1);
    chk("sq_ret_tag", 32'(free_tag.phys_reg), 32'd34);
    chk("sq_ret_count", 32'(free_count), 32'(FL_DEPTH));
    for (int i = 0; i < FL_DEPTH - 2; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("sq_ret_t7", 32'(free_tag.phys_reg), 32'd7);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("sq_ret_t9", 32'(free_tag.phys_reg), 32'd9);

    // Steady state: one dispatch and one retire per cycle, wrapping pointers.
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b1, 6'($urandom_range(0, PHYS_REGS - 1)), 1'b0);
      chk("steady_count", 32'(free_count), 32'(FL_DEPTH - 1));
    end

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      d   = ($urandom_range(0, 3) != 0);
      sq  = ($urandom_range(0, 24) == 0);
      ren = (inflight_q.size() != 0) && ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 7) != 0);
      rt  = 6'($urandom_range(0, PHYS_REGS - 1));
      step(d, ren, rv, rt, sq);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register indices for the R10K-style rename stage.
- Supplies a fresh TAG to the map table on each dispatch that writes a destination register.
- Receives the old TAG (the map table's pre-write value, carried via the ROB) when that instruction retires.
- Tracks a retire pointer so a branch-mispredict squash returns every in-flight allocation in one cycle.

Parameters:
- PHYS_REGS, 64, total physical registers.
- ARCH_REGS, 32, architectural registers; phys 0..ARCH_REGS-1 are mapped at reset.
- DEPTH, PHYS_REGS-ARCH_REGS (32), FIFO entries. Must be a power of two.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dispatch_en  in  1  pop request; rename of an instruction with a destination
- free_tag  out  TAG  head entry: phys_reg = buf[head], valid = ~empty, ready = 0
- retire_en  in  1  retiring instruction had a destination; push its old tag
- retire_tag  in  TAG  old tag to free; only phys_reg used, ignored when valid=0
- squash  in  1  mispredict recovery; discard all un-retired allocations
- empty  out  1  count == 0
- free_count  out  $clog2(DEPTH)+1  number of free entries

Behaviour:
- State: buf[DEPTH] of phys_reg, head, tail, retire_head (each $clog2(DEPTH) bits, natural wrap), count.
- Reset values: buf[i] = ARCH_REGS+i; head = tail = retire_head = 0; count = DEPTH.
- Outputs after reset: free_tag.phys_reg = ARCH_REGS, free_tag.valid = 1, empty = 0, free_count = DEPTH.
- Reset overrides all other inputs in the same cycle.
- Read latency: free_tag is combinational from buf[head], zero latency. The map table samples it in the same cycle that dispatch_en is high.
- pop = dispatch_en & ~empty & ~squash.
  - On pop: head <= head+1, count decrements.
  - dispatch_en while empty is ignored. No stall output; the dispatcher must check empty.
- push = retire_en & retire_tag.valid.
  - On push: buf[tail] <= retire_tag.phys_reg, tail <= tail+1, count increments, retire_head <= retire_head+1.
  - Retire is in-order. Every retire with a destination corresponds to the oldest outstanding allocation.
- Simultaneous pop and push: count unchanged, both pointers advance.
- Empty plus push plus dispatch_en in one cycle: no bypass. The pop is not served; next cycle the head holds the pushed entry.
- Push when count == DEPTH: illegal. Assertion fires; entry dropped; no state change.
- Squash: head <= retire_head_next, where retire_head_next = retire_head+1 if a push occurs this cycle, else retire_head.
  - count <= DEPTH - (tail_next - retire_head_next) wrapped, which equals count_after_push + number of outstanding allocations.
  - Squash has priority over dispatch_en; a push in the same cycle is still honoured.
- Buffer entries between retire_head and head are never overwritten before squash or retire; the tail cannot pass retire_head.
- Invariant: count == DEPTH - ((head - retire_head) mod DEPTH) when no allocations are outstanding. A bench asserts that count never exceeds DEPTH.

Decomposition:
- Shared package (sys_defs): TAG struct {phys_reg, valid, ready}, PHYS_REGS, ARCH_REGS, PHYS_IDX_W.
- No sub-module. The pointer/counter logic is small enough inline.
- An optional generic circular-pointer helper is not warranted.

Test Plan:
- Reset, then 32 consecutive dispatch_en: free_tag.phys_reg = 32,33,...,63; empty = 1 after the 32nd; free_count = 0.
- Empty, dispatch_en held 2 cycles: no pointer change; free_tag.valid = 0; free_count stays 0.
- From empty, retire_en with phys 5 alongside dispatch_en: pop not served; next cycle free_tag.phys_reg = 5, free_count = 1.
- Dispatch 3 (tags 32,33,34), retire 1 (old tag 7), then squash: head returns to entry of tag 33; free_count = 32; tag 7 at the tail.
- Squash in the same cycle as a retire (old 9) and dispatch_en: dispatch ignored; 9 pushed; retire_head advanced before head restore; count consistent.
- Steady state: 1 dispatch + 1 retire every cycle for 100 cycles with wrap-around: free_count constant, FIFO order preserved, no assertion fires.
